// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types and default sizes for the register-file write arbiter.
//   arb_state_t : arbiter FSM state (IDLE / LOCKED)
//   RF_*        : default data width, address width, requester count, max burst.
package rf_arb_pkg;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

  localparam int RF_W    = 8;
  localparam int RF_D    = 3;
  localparam int RF_N    = 2;
  localparam int RF_MAXB = 4;

endpackage

// File: rtl/rf_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   Req    in  N   request vector
//   Last   in  LW  index granted most recently; scan starts at Last+1
//   Gnt    out N   one-hot grant (zero when no request)
//   GntIdx out LW  index of the granted requester (0 when none)
//   Any    out 1   at least one request present
module rr_pick #(
  parameter int N  = 2,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  Req,
  input  logic [LW-1:0] Last,
  output logic [N-1:0]  Gnt,
  output logic [LW-1:0] GntIdx,
  output logic          Any
);

  int j;

  // Walk Last+1 .. Last+N (mod N); the first requester hit wins.
  always_comb begin
    Gnt    = '0;
    GntIdx = '0;
    Any    = 1'b0;
    j      = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(Last) + k) % N;
      if (!Any && Req[j]) begin
        Any    = 1'b1;
        Gnt[j] = 1'b1;
        GntIdx = LW'(j);
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port among N requesters.
// Round-robin arbitration, per-requester valid/ready, optional locked bursts of up
// to MAXB beats. The write port outputs are registered.
// Ports:
//   Clk, Reset               clock, synchronous active-high reset
//   ReqValid/ReqLock [N]     per-requester beat valid / keep-grant request
//   ReqAddr [N*D], ReqData [N*W]  packed per-requester address / data
//   ReqReady [N]             one-hot or zero acceptance
//   WriteEn, Waddr, DataIn   registered regfile write port
//   RaddrA/B, RfDataA/B, FwdDataA/B  read-side forwarding (only with RF_ARB_FWD_EN)
// Build option: define RF_ARB_FWD_EN to add the forwarding ports and mux.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int W    = RF_W,
  parameter int D    = RF_D,
  parameter int N    = RF_N,
  parameter int MAXB = RF_MAXB
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [N-1:0]   ReqValid,
  input  logic [N-1:0]   ReqLock,
  input  logic [N*D-1:0] ReqAddr,
  input  logic [N*W-1:0] ReqData,
`ifdef RF_ARB_FWD_EN
  input  logic [D-1:0]   RaddrA,
  input  logic [D-1:0]   RaddrB,
  input  logic [W-1:0]   RfDataA,
  input  logic [W-1:0]   RfDataB,
  output logic [W-1:0]   FwdDataA,
  output logic [W-1:0]   FwdDataB,
`endif
  output logic [N-1:0]   ReqReady,
  output logic           WriteEn,
  output logic [D-1:0]   Waddr,
  output logic [W-1:0]   DataIn
);

  localparam int LW = $clog2(N);
  localparam int CW = $clog2(MAXB);

  arb_state_t    state;
  logic [LW-1:0] last, owner;
  logic [CW-1:0] burst_cnt;

  logic [N-1:0]  pick_gnt;
  logic [LW-1:0] pick_idx;
  logic          pick_any;

  logic [N-1:0]  gnt;
  logic [LW-1:0] gnt_idx;
  logic          accept;
  logic          lock_sel;
  logic          burst_last;

  rr_pick #(.N(N), .LW(LW)) u_pick (
    .Req    (ReqValid),
    .Last   (last),
    .Gnt    (pick_gnt),
    .GntIdx (pick_idx),
    .Any    (pick_any)
  );

  // In LOCKED only the owner can be served; if it is not valid there is no grant
  // and the burst ends at the next edge.
  always_comb begin
    gnt     = '0;
    gnt_idx = pick_idx;
    accept  = 1'b0;
    if (!Reset) begin
      if (state == IDLE) begin
        gnt    = pick_gnt;
        accept = pick_any;
      end else if (ReqValid[owner]) begin
        gnt[owner] = 1'b1;
        gnt_idx    = owner;
        accept     = 1'b1;
      end
    end
  end

  assign ReqReady   = gnt;
  assign lock_sel   = ReqLock[gnt_idx];
  assign burst_last = (burst_cnt == CW'(MAXB - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      last      <= LW'(N - 1);
      owner     <= '0;
      burst_cnt <= '0;
      WriteEn   <= 1'b0;
      Waddr     <= '0;
      DataIn    <= '0;
    end else begin
      WriteEn <= accept;
      if (accept) begin
        Waddr  <= ReqAddr[gnt_idx*D +: D];
        DataIn <= ReqData[gnt_idx*W +: W];
      end
      if (state == IDLE) begin
        if (accept) begin
          last <= gnt_idx;
          if (lock_sel) begin
            state     <= LOCKED;
            owner     <= gnt_idx;
            burst_cnt <= CW'(1);
          end
        end
      end else begin
        // Burst continues only while the owner keeps beating with lock set and
        // the MAXB cap is not reached; any other case returns to IDLE.
        if (accept && lock_sel && !burst_last) begin
          burst_cnt <= burst_cnt + CW'(1);
        end else begin
          state     <= IDLE;
          burst_cnt <= '0;
        end
      end
    end
  end

`ifdef RF_ARB_FWD_EN
  // The regfile commits one edge after WriteEn rises; bypass that window.
  assign FwdDataA = (WriteEn && RaddrA == Waddr) ? DataIn : RfDataA;
  assign FwdDataB = (WriteEn && RaddrB == Waddr) ? DataIn : RfDataB;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed bench for rf_write_arbiter with a behavioural
// model of the arbitration rules and a per-cycle compare of ReqReady and the
// registered write port. Grant order per test is also pinned by literal strings.
// Define RF_ARB_FWD_EN to include the forwarding ports and their check.
module tb_rf_write_arbiter;

  localparam int W = 8, D = 3, N = 2, MAXB = 4;

  logic           Clk = 1'b0;
  logic           Reset;
  logic [N-1:0]   ReqValid, ReqLock, ReqReady;
  logic [N*D-1:0] ReqAddr;
  logic [N*W-1:0] ReqData;
  logic           WriteEn;
  logic [D-1:0]   Waddr;
  logic [W-1:0]   DataIn;
`ifdef RF_ARB_FWD_EN
  logic [D-1:0]   RaddrA, RaddrB;
  logic [W-1:0]   RfDataA, RfDataB, FwdDataA, FwdDataB;
`endif

  rf_write_arbiter #(.W(W), .D(D), .N(N), .MAXB(MAXB)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ReqValid (ReqValid),
    .ReqLock  (ReqLock),
    .ReqAddr  (ReqAddr),
    .ReqData  (ReqData),
`ifdef RF_ARB_FWD_EN
    .RaddrA   (RaddrA),
    .RaddrB   (RaddrB),
    .RfDataA  (RfDataA),
    .RfDataB  (RfDataB),
    .FwdDataA (FwdDataA),
    .FwdDataB (FwdDataB),
`endif
    .ReqReady (ReqReady),
    .WriteEn  (WriteEn),
    .Waddr    (Waddr),
    .DataIn   (DataIn)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // model state: arbitration rules, not the RTL encoding
  bit           m_locked;
  int           m_last, m_owner, m_cnt;
  logic         m_we;
  logic [D-1:0] m_wa;
  logic [W-1:0] m_wd;
  int           glog[$];   // per non-reset edge: grantee, or -1 for none
  logic [N-1:0] rdy_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_grant();
    if (Reset) return -1;
    if (m_locked) return ReqValid[m_owner] ? m_owner : -1;
    for (int k = 1; k <= N; k++) begin
      if (ReqValid[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    int g;
    g = exp_grant();
    if (Reset) begin
      m_we = 1'b0; m_wa = '0; m_wd = '0;
      m_locked = 1'b0; m_last = N - 1; m_cnt = 0;
    end else begin
      glog.push_back(g);
      if (g < 0) begin
        m_we = 1'b0; m_locked = 1'b0; m_cnt = 0;
      end else begin
        m_we = 1'b1;
        m_wa = ReqAddr[g*D +: D];
        m_wd = ReqData[g*W +: W];
        if (!m_locked) begin
          m_last = g;
          if (ReqLock[g]) begin m_locked = 1'b1; m_owner = g; m_cnt = 1; end
        end else if (ReqLock[g] && m_cnt < MAXB - 1) begin
          m_cnt++;
        end else begin
          m_locked = 1'b0; m_cnt = 0;
        end
      end
    end
  endtask

  // compare at negedge, advance model at posedge, release inputs #1 later
  task automatic tick();
    int g;
    @(negedge Clk);
    g = exp_grant();
    chk("ready", ReqReady, (g < 0) ? 32'd0 : (32'd1 << g));
    chk("we", WriteEn, m_we);
    chk("waddr", Waddr, m_wa);
    chk("datain", DataIn, m_wd);
    rdy_s = ReqReady;
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit l, input int a, input int d);
    ReqValid[i] = v;
    ReqLock[i]  = l;
    ReqAddr[i*D +: D] = D'(a);
    ReqData[i*W +: W] = W'(d);
  endtask

  // expected grant sequence as a string: digit = grantee, '.' = no grant
  task automatic check_log(input string name, input string s);
    int e, a;
    for (int i = 0; i < s.len(); i++) begin
      e = (s[i] == ".") ? -1 : int'(s[i]) - 48;
      a = (i < glog.size()) ? glog[i] : 99;
      chk($sformatf("%s_grant%0d", name, i), a, e);
    end
  endtask

  int rem0, rem1;

  initial begin
    Reset = 1'b1;
    ReqValid = '0; ReqLock = '0; ReqAddr = '0; ReqData = '0;
`ifdef RF_ARB_FWD_EN
    RaddrA = '0; RaddrB = '0; RfDataA = '0; RfDataB = '0;
`endif
    // 1: reset with all requesters valid
    set_req(0, 1, 0, 1, 'hAA);
    set_req(1, 1, 0, 2, 'hBB);
    @(posedge Clk); model_step(); #1;
    tick(); tick();
    chk("rst_ready", ReqReady, 0);
    chk("rst_we", WriteEn, 0);
    chk("rst_waddr", Waddr, 0);
    chk("rst_datain", DataIn, 0);
    Reset = 1'b0;
    glog.delete();

    // 2: both valid, no lock -> alternate starting at 0
    repeat (4) tick();
    chk("t2_we", WriteEn, 1);
    chk("t2_waddr", Waddr, 2);
    chk("t2_datain", DataIn, 'hBB);
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
    check_log("t2", "0101");
    tick();
    chk("t2_idle_we", WriteEn, 0);
    chk("t2_hold_datain", DataIn, 'hBB);

    // 3: Req1 6-beat locked burst capped at 4, Req0 waiting
    set_req(0, 1, 0, 4, 'h10);
    tick();                       // Req0 alone -> Last=0
    glog.delete();
    rem0 = 1; rem1 = 6;
    for (int t = 0; t < 20 && (rem0 > 0 || rem1 > 0); t++) begin
      set_req(0, rem0 > 0, 0, 4, 'h10);
      set_req(1, rem1 > 0, rem1 > 1, 5, 'hC0 + 6 - rem1);
      tick();
      if (ReqValid[0] && rdy_s[0]) rem0--;
      if (ReqValid[1] && rdy_s[1]) rem1--;
    end
    chk("t3_done", rem0 + rem1, 0);
    check_log("t3", "1111011");
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
    tick();

    // 4: Req0 locks, drops after 2 beats -> bubble, then Req1
    glog.delete();
    rem0 = 2; rem1 = 1;
    for (int t = 0; t < 10 && rem1 > 0; t++) begin
      set_req(0, rem0 > 0, 1, 6, 'h40 + rem0);
      set_req(1, rem1 > 0, 0, 7, 'h77);
      tick();
      if (ReqValid[0] && rdy_s[0]) rem0--;
      if (ReqValid[1] && rdy_s[1]) rem1--;
    end
    chk("t4_done", rem1, 0);
    check_log("t4", "00.1");
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
    tick();

    // 5: reset in LOCKED after beat 2 -> Last restored to N-1
    glog.delete();
    set_req(0, 1, 1, 3, 'h33);
    tick(); tick();
    set_req(1, 1, 0, 2, 'h22);
    Reset = 1'b1;
    tick();
    chk("t5_rst_ready", ReqReady, 0);
    chk("t5_rst_we", WriteEn, 0);
    chk("t5_rst_waddr", Waddr, 0);
    chk("t5_rst_datain", DataIn, 0);
    Reset = 1'b0;
    set_req(0, 1, 0, 3, 'h34);
    tick(); tick();
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
    check_log("t5", "0001");
    tick();

`ifdef RF_ARB_FWD_EN
    // 6: forward a pending write to the read ports
    set_req(0, 1, 0, 3, 'h5A);
    tick();
    set_req(0, 0, 0, 0, 0);
    RaddrA = 3; RfDataA = 'h00; RaddrB = 2; RfDataB = 'h77;
    #1;
    chk("t6_fwdA", FwdDataA, 'h5A);
    chk("t6_fwdB", FwdDataB, 'h77);
    tick();
    RfDataA = 'h5A;
    #1;
    chk("t6_fwdA_after", FwdDataA, 'h5A);
    RfDataA = 'h11;
    #1;
    chk("t6_noforward", FwdDataA, 'h11);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
